// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: opcode width, opcode
// encodings and the FSM state encoding.
package ctrl_pkg;

    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OP_LOAD  = 7'h01;
    localparam logic [OPC_W-1:0] OP_STORE = 7'h02;
    localparam logic [OPC_W-1:0] OP_ADD   = 7'h03;
    localparam logic [OPC_W-1:0] OP_SUB   = 7'h04;
    localparam logic [OPC_W-1:0] OP_ADDI  = 7'h05;
    localparam logic [OPC_W-1:0] OP_SUBI  = 7'h06;
    localparam logic [OPC_W-1:0] OP_HALT  = 7'h7F;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StLoadIr,
        StDecode,
        StExec,
        StMem,
        StMemWait,
        StWb,
        StHalt
    } state_e;

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode classifier.
//   opcode     in   OPC_W  opcode to classify
//   is_mem     out  1      LOAD or STORE
//   is_load    out  1      LOAD
//   is_alu     out  1      ADD, SUB, ADDI, SUBI
//   uses_rb    out  1      register-register ALU op (ADD, SUB)
//   is_halt    out  1      HALT
//   is_illegal out  1      any undefined opcode
module op_decoder
    import ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic             is_mem,
    output logic             is_load,
    output logic             is_alu,
    output logic             uses_rb,
    output logic             is_halt,
    output logic             is_illegal
);

    always_comb begin
        is_mem     = 1'b0;
        is_load    = 1'b0;
        is_alu     = 1'b0;
        uses_rb    = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        unique case (opcode)
            OP_LOAD: begin
                is_mem  = 1'b1;
                is_load = 1'b1;
            end
            OP_STORE: is_mem = 1'b1;
            OP_ADD, OP_SUB: begin
                is_alu  = 1'b1;
                uses_rb = 1'b1;
            end
            OP_ADDI, OP_SUBI: is_alu = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM for the 64-bit load/store datapath. Sequences
// fetch/decode/execute/memory/writeback, counts retired instructions and
// stops on HALT or an undefined opcode.
//   clk      in   1      system clock
//   rst      in   1      synchronous active-high reset
//   start    in   1      begin execution from IDLE
//   opcode   in   OPC_W  IR opcode
//   pc_we    out  1      PC load enable
//   ir_we    out  1      IR load enable
//   rf_we    out  1      register bank write enable
//   dmem_we  out  1      data memory write enable
//   imm_sel  out  1      Mux1 select: 0 = immediate, 1 = Rb
//   wb_sel   out  1      Mux2 select: 0 = data memory, 1 = ULA
//   alu_op   out  OPC_W  opcode forwarded to ULA
//   busy     out  1      executing (not IDLE/HALT)
//   halted   out  1      in HALT
//   illegal  out  1      sticky: halted on undefined opcode
//   retired  out  CNT_W  retired-instruction count (wraps)
module control_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter bit          AUTO_START = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPC_W-1:0] opcode,
    output logic             pc_we,
    output logic             ir_we,
    output logic             rf_we,
    output logic             dmem_we,
    output logic             imm_sel,
    output logic             wb_sel,
    output logic [OPC_W-1:0] alu_op,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [CNT_W-1:0] CntOne = 1;

    state_e           state_q, state_d;
    logic [OPC_W-1:0] op_q, op_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [OPC_W-1:0] dec_opc;
    logic             is_mem, is_load, is_alu, uses_rb, is_halt, is_illegal;

    // In DECODE the live opcode steers the branch; elsewhere only op_q matters.
    // No output depends on the decode flags while in DECODE, so outputs stay Moore.
    assign dec_opc = (state_q == StDecode) ? opcode : op_q;

    op_decoder u_op_decoder (
        .opcode     (dec_opc),
        .is_mem     (is_mem),
        .is_load    (is_load),
        .is_alu     (is_alu),
        .uses_rb    (uses_rb),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        rf_we     = 1'b0;
        dmem_we   = 1'b0;
        imm_sel   = 1'b0;
        wb_sel    = 1'b0;
        alu_op    = '0;
        busy      = 1'b0;
        halted    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start || AUTO_START) state_d = StFetch;
            end
            StFetch: begin
                busy    = 1'b1;
                state_d = StLoadIr;
            end
            StLoadIr: begin
                busy    = 1'b1;
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                busy = 1'b1;
                op_d = opcode;
                if (is_halt) begin
                    state_d = StHalt;
                end else if (is_illegal) begin
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                busy    = 1'b1;
                alu_op  = op_q;
                imm_sel = uses_rb;
                state_d = is_mem ? StMem : StWb;
            end
            StMem: begin
                busy   = 1'b1;
                alu_op = op_q;
                if (is_load) begin
                    state_d = StMemWait;
                end else begin
                    dmem_we   = 1'b1;
                    retired_d = retired_q + CntOne;
                    state_d   = StFetch;
                end
            end
            StMemWait: begin
                busy    = 1'b1;
                alu_op  = op_q;
                state_d = StWb;
            end
            StWb: begin
                busy      = 1'b1;
                rf_we     = 1'b1;
                wb_sel    = is_alu;  // only ALU ops and LOAD reach WB
                alu_op    = op_q;
                imm_sel   = uses_rb;
                retired_d = retired_q + CntOne;
                state_d   = StFetch;
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    localparam logic [6:0] LOAD  = 7'h01;
    localparam logic [6:0] STORE = 7'h02;
    localparam logic [6:0] ADD   = 7'h03;
    localparam logic [6:0] SUB   = 7'h04;
    localparam logic [6:0] ADDI  = 7'h05;
    localparam logic [6:0] SUBI  = 7'h06;
    localparam logic [6:0] HALT  = 7'h7F;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [6:0]  opcode;

    logic        pc_we, ir_we, rf_we, dmem_we, imm_sel, wb_sel, busy, halted, illegal;
    logic [6:0]  alu_op;
    logic [15:0] retired;

    logic        pc_we_w, ir_we_w, rf_we_w, dmem_we_w, imm_sel_w, wb_sel_w;
    logic        busy_w, halted_w, illegal_w;
    logic [6:0]  alu_op_w;
    logic [1:0]  retired_w;

    logic [15:0] obs, obs_w;
    assign obs   = {pc_we, ir_we, rf_we, dmem_we, imm_sel, wb_sel, busy, halted, illegal, alu_op};
    assign obs_w = {pc_we_w, ir_we_w, rf_we_w, dmem_we_w, imm_sel_w, wb_sel_w,
                    busy_w, halted_w, illegal_w, alu_op_w};

    control_unit #(.CNT_W(16), .AUTO_START(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we), .dmem_we(dmem_we),
        .imm_sel(imm_sel), .wb_sel(wb_sel), .alu_op(alu_op), .busy(busy),
        .halted(halted), .illegal(illegal), .retired(retired)
    );

    control_unit #(.CNT_W(2), .AUTO_START(1'b0)) dut_w (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .pc_we(pc_we_w), .ir_we(ir_we_w), .rf_we(rf_we_w), .dmem_we(dmem_we_w),
        .imm_sel(imm_sel_w), .wb_sel(wb_sel_w), .alu_op(alu_op_w), .busy(busy_w),
        .halted(halted_w), .illegal(illegal_w), .retired(retired_w)
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    int unsigned m_ret = 0;   // instructions retired since reset
    logic        m_ill = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction classes: 0 ALU, 1 LOAD, 2 STORE, 3 HALT, 4 illegal
    function automatic int cls_of(input logic [6:0] op);
        if (op == ADD || op == SUB || op == ADDI || op == SUBI) return 0;
        if (op == LOAD) return 1;
        if (op == STORE) return 2;
        if (op == HALT) return 3;
        return 4;
    endfunction

    // Cycles spent from FETCH until the next FETCH (or until HALT is entered)
    function automatic int len_of(input int c);
        if (c == 0 || c == 2) return 5;
        if (c == 1) return 7;
        return 3;
    endfunction

    // Expected outputs at cycle k of an instruction (k = 0 is FETCH)
    function automatic logic [15:0] exp_step(input logic [6:0] op, input int k);
        int         c;
        logic       pc, ir, rf, dm, imm, wb;
        logic [6:0] alu;
        c = cls_of(op);
        pc = 1'b0; ir = 1'b0; rf = 1'b0; dm = 1'b0; imm = 1'b0; wb = 1'b0; alu = 7'h0;
        if (k == 1) begin pc = 1'b1; ir = 1'b1; end
        if (k >= 3) alu = op;
        if (c == 0 && k >= 3) imm = (op == ADD || op == SUB);
        if (c == 0 && k == 4) begin rf = 1'b1; wb = 1'b1; end
        if (c == 2 && k == 4) dm = 1'b1;
        if (c == 1 && k == 6) rf = 1'b1;
        return {pc, ir, rf, dm, imm, wb, 1'b1, 1'b0, 1'b0, alu};
    endfunction

    function automatic logic [15:0] halt_vec(input logic ill);
        return {6'b0, 1'b0, 1'b1, ill, 7'h0};
    endfunction

    task automatic observe(input string tag, input logic [15:0] exp);
        check_eq({tag, ".out"}, 32'(obs), 32'(exp));
        check_eq({tag, ".ret"}, 32'(retired), m_ret & 32'hFFFF);
        check_eq({tag, ".out_w"}, 32'(obs_w), 32'(exp));
        check_eq({tag, ".ret_w"}, 32'(retired_w), m_ret & 32'h3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        start  = 1'($urandom);
        opcode = 7'($urandom);
        @(negedge clk);
        m_ret = 0;
        m_ill = 1'b0;
        observe("reset", 16'h0);
        rst   = 1'b0;
        start = 1'b0;
    endtask

    // Reset, idle briefly, then pulse start so the next sample sees FETCH
    task automatic begin_prog();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            observe("idle", 16'h0);
            opcode = 7'($urandom);
            start  = (i == 1);
        end
    endtask

    task automatic run_inst(input logic [6:0] op, input int rst_at, output bit aborted);
        int c, n;
        c = cls_of(op);
        n = len_of(c);
        aborted = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            observe($sformatf("op%02h.k%0d", op, k), exp_step(op, k));
            opcode = (k == 2) ? op : 7'($urandom);
            start  = 1'($urandom);
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                m_ret = 0;
                m_ill = 1'b0;
                observe($sformatf("midrst.op%02h.k%0d", op, k), 16'h0);
                rst   = 1'b0;
                start = 1'b0;
                for (int j = 0; j < 2; j++) begin
                    @(negedge clk);
                    observe("post_rst", 16'h0);
                end
                aborted = 1'b1;
                return;
            end
        end
        if (c <= 2) m_ret++;
        else m_ill = (c == 4);
    endtask

    task automatic halt_wait(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            observe("halt", halt_vec(m_ill));
            start  = 1'b1;
            opcode = 7'($urandom);
        end
    endtask

    function automatic logic [6:0] rand_op();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) begin
            case (r % 4)
                0: return ADD;
                1: return SUB;
                2: return ADDI;
                default: return SUBI;
            endcase
        end
        return (r < 8) ? LOAD : STORE;
    endfunction

    function automatic logic [6:0] rand_illegal();
        logic [6:0] op;
        do op = 7'($urandom); while (cls_of(op) != 4);
        return op;
    endfunction

    bit ab;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        opcode = 7'h0;
        repeat (2) @(negedge clk);

        // Every instruction kind, then HALT; start must be ignored while halted
        begin_prog();
        run_inst(ADD, -1, ab);
        run_inst(LOAD, -1, ab);
        run_inst(STORE, -1, ab);
        run_inst(ADDI, -1, ab);
        run_inst(SUBI, -1, ab);
        run_inst(HALT, -1, ab);
        halt_wait(4);

        // Five ALU ops wrap the 2-bit counter, then an illegal opcode halts
        begin_prog();
        run_inst(ADD, -1, ab);
        run_inst(SUB, -1, ab);
        run_inst(ADDI, -1, ab);
        run_inst(SUBI, -1, ab);
        run_inst(ADD, -1, ab);
        run_inst(7'h10, -1, ab);
        halt_wait(3);

        // Reset in MEM of STORE and in WB of ADD
        begin_prog();
        run_inst(ADDI, -1, ab);
        run_inst(STORE, 4, ab);
        begin_prog();
        run_inst(ADD, 4, ab);

        // Random programs with occasional mid-instruction reset
        for (int p = 0; p < 25; p++) begin
            int  len;
            bit  stopped;
            begin_prog();
            len = $urandom_range(1, 12);
            stopped = 1'b0;
            for (int i = 0; i < len && !stopped; i++) begin
                logic [6:0] op;
                int         ra;
                op = rand_op();
                ra = ($urandom_range(0, 19) == 0) ? $urandom_range(0, len_of(cls_of(op)) - 1) : -1;
                run_inst(op, ra, ab);
                stopped = ab;
            end
            if (!stopped) begin
                run_inst(($urandom_range(0, 1) == 0) ? HALT : rand_illegal(), -1, ab);
                halt_wait(2);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
